// File: rtl/alu_cmd_pkg.sv
// Shared command layout and issuer state encoding for the ALU command path.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package alu_cmd_pkg;

   localparam int CMD_W  = 12;
   localparam int OP_MSB = 11;
   localparam int OP_LSB = 9;
   localparam int A1_MSB = 8;
   localparam int A1_LSB = 6;
   localparam int A2_MSB = 5;
   localparam int A2_LSB = 3;
   localparam int A3_MSB = 2;
   localparam int A3_LSB = 0;

   localparam logic [2:0] OP_CAS = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      ISSUE = 2'd2,
      WAIT  = 2'd3
   } issuer_state_t;

   // True when the command carries the compare-and-swap opcode.
   function automatic logic is_cas(input logic [CMD_W-1:0] cmd);
      return cmd[OP_MSB:OP_LSB] == OP_CAS;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// DEPTH x CMD_W synchronous FIFO with flush; head is visible combinationally.
// Latency: a push is poppable on the next cycle; count updates on the push/pop edge.
// Backpressure: pushes while full and pops while empty are dropped; flush beats push.
module cmd_fifo
   import alu_cmd_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [CMD_W-1:0]         push_dat_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [CMD_W-1:0]         head_dat_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [CMD_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o     = (count_q == (AW+1)'(DEPTH));
   assign empty_o    = (count_q == '0);
   assign head_dat_o = mem_q[rd_ptr_q];
   assign count_o    = count_q;

   // Full gates the push even if a pop frees a slot this same cycle.
   assign do_push = push_i && !full_o && !flush_i;
   assign do_pop  = pop_i && !empty_o;

   // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are meaningless until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
   end

endmodule

// File: rtl/command_issuer.sv
// Buffers host commands and issues them one at a time to the ALU controller with a RUN pulse.
// Latency: pop -> command next cycle, syscall one cycle later; ALU ops every 4 cycles back-to-back.
// Backpressure: cmd_ready drops when the FIFO is full; ctrl_ready low holds issue in IDLE. Option: CAS_RETRY_EN.
module command_issuer
   import alu_cmd_pkg::*;
#(
   parameter int DEPTH     = 8,
   parameter int ALU_WAIT  = 1,
   parameter int CAS_WAIT  = 2,
   parameter int MAX_RETRY = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [CMD_W-1:0]         cmd_in,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic                     flush,
   input  logic                     ctrl_ready,
   input  logic                     cas_ok,
   output logic [CMD_W-1:0]         command,
   output logic                     syscall,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     cas_fail
);

   localparam int WMAX   = (ALU_WAIT > CAS_WAIT) ? ALU_WAIT : CAS_WAIT;
   localparam int WAIT_W = $clog2(WMAX + 1);

   issuer_state_t     state_q, state_d;
   logic [CMD_W-1:0]  command_q, command_d;
   logic              syscall_q, syscall_d;
   logic              cas_fail_q, cas_fail_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              pop;
   logic [CMD_W-1:0]  head_dat;
   logic              fifo_full, fifo_empty;

`ifdef CAS_RETRY_EN
   localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   logic [RETRY_W-1:0] retry_q, retry_d;
`endif

   cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (cmd_valid),
      .push_dat_i (cmd_in),
      .pop_i      (pop),
      .flush_i    (flush),
      .head_dat_o (head_dat),
      .count_o    (fifo_count),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   assign cmd_ready = !fifo_full;
   assign command   = command_q;
   assign syscall   = syscall_q;
   assign cas_fail  = cas_fail_q;
   assign busy      = (state_q != IDLE);

   // Issue sequencer: pop in IDLE, settle in SETUP, pulse in ISSUE, hold off in WAIT.
   always_comb begin
      state_d    = state_q;
      command_d  = command_q;
      syscall_d  = 1'b0;
      cas_fail_d = 1'b0;
      wait_d     = wait_q;
      pop        = 1'b0;
`ifdef CAS_RETRY_EN
      retry_d    = retry_q;
`endif
      case (state_q)
         IDLE: begin
            if (!fifo_empty && ctrl_ready) begin
               pop       = 1'b1;
               command_d = head_dat;
               state_d   = SETUP;
`ifdef CAS_RETRY_EN
               retry_d   = '0;
`endif
            end
         end
         SETUP: begin
            // syscall is registered, so raising it here makes it high during ISSUE.
            syscall_d = 1'b1;
            state_d   = ISSUE;
         end
         ISSUE: begin
            wait_d  = is_cas(command_q) ? WAIT_W'(CAS_WAIT) : WAIT_W'(ALU_WAIT);
            state_d = WAIT;
         end
         WAIT: begin
            if (wait_q <= WAIT_W'(1)) begin
               wait_d  = '0;
               state_d = IDLE;
               if (is_cas(command_q) && !cas_ok) begin
`ifdef CAS_RETRY_EN
                  if (retry_q < RETRY_W'(MAX_RETRY)) begin
                     retry_d = retry_q + 1'b1;
                     state_d = SETUP;
                  end else begin
                     cas_fail_d = 1'b1;
                  end
`else
                  cas_fail_d = 1'b1;
`endif
               end
            end else begin
               wait_d = wait_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Sequencer registers; reset drops any in-flight pulse at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         command_q  <= '0;
         syscall_q  <= 1'b0;
         cas_fail_q <= 1'b0;
         wait_q     <= '0;
      end else begin
         state_q    <= state_d;
         command_q  <= command_d;
         syscall_q  <= syscall_d;
         cas_fail_q <= cas_fail_d;
         wait_q     <= wait_d;
      end
   end

`ifdef CAS_RETRY_EN
   // CAS re-issue counter, cleared whenever a fresh command is popped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) retry_q <= '0;
      else        retry_q <= retry_d;
   end
`endif

endmodule
